apb2axi_rd_resp_collector: RTL
==============================

Name: apb2axi_rd_resp_collector

Overview:
- Receives AXI read-data beats (R channel) for one outstanding read burst at a time.
- Buffers the beats and checks ID, length and response codes.
- Replays the beats to the APB-side consumer over a valid/ready handshake, with a sticky burst-wide error flag.
- Sits between the AXI master R channel and the APB read-return path. It is the return direction of the bridge's command queueing.

Parameters:
- DATA_W, 32, width of R data and of drained words.
- MAX_BEATS, 16, buffer depth in beats (power of 2, at least 2).
- ID_W, 4, AXI ID width.

Ports:
- clk in 1: clock.
- resetn in 1: asynchronous, active-low reset.
- exp_valid in 1: expected-burst descriptor valid.
- exp_ready out 1: descriptor accepted.
- exp_len in 8: expected beats minus 1 (AXI ARLEN encoding).
- exp_id in ID_W: expected RID.
- r_valid in 1: AXI RVALID.
- r_ready out 1: AXI RREADY.
- r_data in DATA_W: AXI RDATA.
- r_resp in 2: AXI RRESP.
- r_last in 1: AXI RLAST.
- r_id in ID_W: AXI RID.
- rd_valid out 1: drained beat valid.
- rd_ready in 1: consumer ready.
- rd_data out DATA_W: drained beat data.
- rd_err out 1: burst error flag.
- rd_last out 1: final drained beat.
- rd_id out ID_W: ID of the burst being drained.

Behaviour:
- Reset (async, resetn low): FSM=IDLE; exp_ready=1; r_ready=0; rd_valid=0; rd_data=0; rd_err=0; rd_last=0; rd_id=0; all counters and flags cleared. Buffer storage is not reset.
- FSM states: IDLE, COLLECT, DRAIN.
- IDLE:
  - exp_ready=1, r_ready=0, rd_valid=0.
  - On exp_valid & exp_ready: latch len=exp_len and id=exp_id; clear wr_cnt, rd_idx and err; go to COLLECT next cycle.
- COLLECT:
  - exp_ready=0, r_ready=1.
  - Each beat accepted (r_valid & r_ready):
    - If wr_cnt < MAX_BEATS, write buf[wr_cnt]=r_data; otherwise discard the data and set err.
    - Set err if r_resp[1]=1 (SLVERR/DECERR). EXOKAY is treated as OKAY.
    - Set err if r_id != latched id.
    - wr_cnt increments, saturating at MAX_BEATS.
  - COLLECT ends only on an accepted beat with r_last=1.
    - On that beat, set err if its beat index != len, whether r_last is early or late.
    - Go to DRAIN next cycle. r_ready drops to 0 the cycle after the r_last beat.
  - Stored count = min(beats received, MAX_BEATS). It is always at least 1, because the r_last beat itself is received.
- DRAIN:
  - r_ready=0, exp_ready=0, rd_valid=1.
  - rd_data=buf[rd_idx]; rd_id=latched id; rd_err=final err (same value on every beat of the burst).
  - rd_last=1 when rd_idx == stored-1.
  - On rd_valid & rd_ready: rd_idx increments. If rd_last, go to IDLE next cycle.
  - rd_valid/rd_data/rd_last/rd_err/rd_id stay stable while rd_valid=1 and rd_ready=0.
- Outside DRAIN, rd_data/rd_err/rd_last/rd_id are driven 0.
- Latency:
  - Descriptor accept to r_ready high: 1 cycle.
  - r_last accept to first rd_valid: 1 cycle.
  - Drain throughput: 1 beat/cycle when rd_ready is held high.
- Minimum turnaround after the final rd handshake: IDLE for 1 cycle. exp_ready is high in that cycle, so a new descriptor can be accepted there.
- r_valid asserted in IDLE or DRAIN: ignored (r_ready=0), no state change.
- rd_ready asserted outside DRAIN: ignored.
- Single-beat burst (len=0, r_last on the first beat): stored=1; one drained beat with rd_last=1.
- Reset asserted mid-COLLECT or mid-DRAIN: immediately return to IDLE and apply reset output values. A partially collected burst is lost.
- All counters are sized to hold MAX_BEATS without wrap. The wr_cnt saturation guarantees no buffer-index wrap or overwrite.

Test Plan:
- Nominal 4-beat burst: exp_len=3, exp_id=5; R beats 0xA0..0xA3, resp=OKAY, id=5, r_last on beat 3; rd_ready=1.
  -> rd_valid rises 1 cycle after r_last.
  -> Drained data 0xA0,0xA1,0xA2,0xA3 on 4 consecutive cycles; rd_last only on 0xA3; rd_err=0; rd_id=5; IDLE next cycle.
- Error response: exp_len=1; beat 0 resp=OKAY, beat 1 resp=2'b10 (SLVERR) with r_last.
  -> Both drained beats have rd_err=1.
- ID mismatch and early last: exp_len=3, exp_id=2; two beats with id=3, r_last on beat 1.
  -> 2 beats drained; rd_err=1; rd_last on beat 1.
- Overflow: MAX_BEATS=16, exp_len=19; 20 beats, data=index, r_last on beat 19.
  -> Data 0..15 drained; rd_last on data 15; rd_err=1; no overwrite of entries 0..3.
- Consumer backpressure: 3-beat burst with rd_ready toggled 0,0,1,0,1,1.
  -> rd_data/rd_last held stable during stalls; exactly 3 handshakes in order.
  -> r_ready=0 and exp_ready=0 throughout DRAIN.
- Reset mid-burst: resetn pulsed low after 2 of 4 beats.
  -> All outputs at reset values; exp_ready=1.
  -> A following 1-beat burst (exp_len=0, data 0x55) drains 0x55 with rd_last=1, rd_err=0.

Source files
------------

// File: rtl/apb2axi_rd_resp_collector.sv
// AXI R-channel collector: buffers one read burst, checks ID/length/response,
// then replays the beats to the APB-side consumer with a burst-wide error flag.
module apb2axi_rd_resp_collector #(
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 16,
  parameter int ID_W      = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic [7:0]        exp_len,
  input  logic [ID_W-1:0]   exp_id,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [DATA_W-1:0] r_data,
  input  logic [1:0]        r_resp,
  input  logic              r_last,
  input  logic [ID_W-1:0]   r_id,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  output logic              rd_last,
  output logic [ID_W-1:0]   rd_id
);

  localparam int AW = $clog2(MAX_BEATS);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;

  logic [1:0]        state;
  logic [7:0]        len_q;
  logic [ID_W-1:0]   id_q;
  logic [CW-1:0]     wr_cnt;
  logic [CW-1:0]     rd_idx;
  logic [8:0]        beat_cnt;
  logic              err_q;
  logic [DATA_W-1:0] mem [MAX_BEATS];

  logic in_idle, in_collect, in_drain;
  logic desc_acc, beat_acc, rd_acc;
  logic full, beat_err, last_idx;

  assign in_idle    = (state == S_IDLE);
  assign in_collect = (state == S_COLLECT);
  assign in_drain   = (state == S_DRAIN);

  assign desc_acc = in_idle & exp_valid;
  assign beat_acc = in_collect & r_valid;
  assign rd_acc   = in_drain & rd_ready;

  assign full = (wr_cnt == CW'(MAX_BEATS));

  // beat_cnt saturates at 256, which can never match an 8-bit len, so very
  // long bursts still flag a length error without wrapping.
  assign beat_err = full | r_resp[1] | (r_id != id_q) |
                    (r_last & (beat_cnt != {1'b0, len_q}));

  assign last_idx = (rd_idx == (wr_cnt - CW'(1)));

  assign exp_ready = in_idle;
  assign r_ready   = in_collect;
  assign rd_valid  = in_drain;
  assign rd_data   = in_drain ? mem[rd_idx[AW-1:0]] : '0;
  assign rd_err    = in_drain & err_q;
  assign rd_last   = in_drain & last_idx;
  assign rd_id     = in_drain ? id_q : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      len_q    <= '0;
      id_q     <= '0;
      wr_cnt   <= '0;
      rd_idx   <= '0;
      beat_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (desc_acc) begin
            len_q    <= exp_len;
            id_q     <= exp_id;
            wr_cnt   <= '0;
            rd_idx   <= '0;
            beat_cnt <= '0;
            err_q    <= 1'b0;
            state    <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (beat_acc) begin
            if (!full) wr_cnt <= wr_cnt + CW'(1);
            if (beat_cnt != 9'h100) beat_cnt <= beat_cnt + 9'd1;
            err_q <= err_q | beat_err;
            if (r_last) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (rd_acc) begin
            rd_idx <= rd_idx + CW'(1);
            if (last_idx) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (beat_acc && !full) mem[wr_cnt[AW-1:0]] <= r_data;
  end

endmodule
